// File: rtl/midi_note_rx.sv
// midi_note_rx
// Receives serial MIDI on a single pin and decodes monophonic Note On/Off
// messages for the tone path. The decoded note drives the sine generator's
// frequency-modulation input, and the velocity drives the amplifier's
// amplitude input while a note is held.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   midi_in    - raw serial MIDI, idle high, asynchronous to clk
//   note       - current note number
//   velocity   - velocity of the current note
//   gate       - high while a note is held
//   note_valid - one-cycle pulse on every accepted Note On/Off event
//   freq_mod   - note scaled for the sine generator: {note, 3'b000}
//   amp        - gate ? {velocity, velocity[6:4]} : 0
//   frame_err  - one-cycle pulse when a stop bit samples low
module midi_note_rx #(
  parameter int CLKSPEED = 48_000_000,
  parameter int BAUD     = 31250,
  parameter int CHANNEL  = 0,
  parameter int OMNI     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_valid,
  output logic [9:0] freq_mod,
  output logic [9:0] amp,
  output logic       frame_err
);

  localparam int DIV = CLKSPEED / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {P_IDLE, P_WAIT_D1, P_WAIT_D2} parseState_t;
  typedef enum logic [1:0] {RS_NONE, RS_ON, RS_OFF, RS_IGNORE} runStatus_t;

  logic          r_sync1;
  logic          r_sync2;
  rxState_t      r_rxState;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_stopWait;
  logic          r_byteValid;
  logic [7:0]    r_rxByte;

  parseState_t   r_pState;
  runStatus_t    r_runStatus;
  logic [6:0]    r_d1;

  logic          w_chanOk;

  // Two-flop synchronizer; resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= midi_in;
      r_sync2 <= r_sync1;
    end
  end

  // UART receiver. The start bit is re-checked at its midpoint, so every
  // later sample lands mid-bit. A low stop bit parks the receiver until the
  // line returns high, so a broken frame cannot masquerade as a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxState   <= RX_IDLE;
      r_cnt       <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_stopWait  <= 1'b0;
      r_byteValid <= 1'b0;
      r_rxByte    <= '0;
      frame_err   <= 1'b0;
    end else begin
      r_byteValid <= 1'b0;
      frame_err   <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          r_cnt      <= '0;
          r_bitIdx   <= '0;
          r_stopWait <= 1'b0;
          if (!r_sync2) r_rxState <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt     <= '0;
            r_rxState <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bitIdx == 3'd7) r_rxState <= RX_STOP;
            else r_bitIdx <= r_bitIdx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_stopWait) begin
            if (r_sync2) r_rxState <= RX_IDLE;
          end else if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_byteValid <= 1'b1;
              r_rxByte    <= r_shift;
              r_rxState   <= RX_IDLE;
            end else begin
              frame_err  <= 1'b1;
              r_stopWait <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  assign w_chanOk = (OMNI != 0) || (r_rxByte[3:0] == 4'(CHANNEL));

  // Message parser and event apply. Realtime bytes fall through untouched so
  // they can interleave with data bytes. Unaccepted channel messages still
  // advance through D1/D2 so their data pairs are swallowed cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pState    <= P_IDLE;
      r_runStatus <= RS_NONE;
      r_d1        <= '0;
      note        <= '0;
      velocity    <= '0;
      gate        <= 1'b0;
      note_valid  <= 1'b0;
      freq_mod    <= '0;
      amp         <= '0;
    end else begin
      note_valid <= 1'b0;
      if (r_byteValid) begin
        if (r_rxByte[7]) begin
          if (r_rxByte >= 8'hF8) begin
            r_pState <= r_pState;
          end else if (r_rxByte >= 8'hF0) begin
            r_runStatus <= RS_NONE;
            r_pState    <= P_IDLE;
          end else if (w_chanOk && r_rxByte[7:4] == 4'h9) begin
            r_runStatus <= RS_ON;
            r_pState    <= P_WAIT_D1;
          end else if (w_chanOk && r_rxByte[7:4] == 4'h8) begin
            r_runStatus <= RS_OFF;
            r_pState    <= P_WAIT_D1;
          end else begin
            r_runStatus <= RS_IGNORE;
            r_pState    <= P_WAIT_D1;
          end
        end else begin
          case (r_pState)
            P_WAIT_D1: begin
              r_d1     <= r_rxByte[6:0];
              r_pState <= P_WAIT_D2;
            end
            P_WAIT_D2: begin
              r_pState <= P_WAIT_D1;
              if (r_runStatus == RS_ON && r_rxByte[6:0] != 7'd0) begin
                note       <= r_d1;
                velocity   <= r_rxByte[6:0];
                gate       <= 1'b1;
                note_valid <= 1'b1;
                freq_mod   <= {r_d1, 3'b000};
                amp        <= {r_rxByte[6:0], r_rxByte[6:4]};
              end else if ((r_runStatus == RS_ON || r_runStatus == RS_OFF) &&
                           r_d1 == note && gate) begin
                gate       <= 1'b0;
                note_valid <= 1'b1;
                amp        <= '0;
              end
            end
            default: r_pState <= P_IDLE;
          endcase
        end
      end
    end
  end

endmodule
